// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and helpers for the fp_add arbiter.
// Optional feature macro: FP_ARB_RSP_REG_EN (registered response outputs).
// FP_ADD_LAT supplies the default adder latency when not set by the build.

`ifndef FP_ADD_LAT
`define FP_ADD_LAT 4
`endif

package fp_add_arbiter_pkg;

    // Default pipeline depth of the shared adder.
    localparam int FP_ADD_LAT_DEFAULT = `FP_ADD_LAT;

    // Arbiter states: open arbitration, or serving one requester's burst.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Circular increment of a requester index.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_picker.sv
// Combinational circular priority encoder: first request at or after ptr.

module fp_add_arbiter_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int               sum;
    logic [IDX_W-1:0] cand;

    // Walk the requests starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IDX_W'(sum);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined fp_add among NUM_REQ requesters. Round-robin grant
// with burst locking; a tag pipeline of FP_LAT slots routes each result back
// to its issuer exactly FP_LAT cycles after issue.
// Optional feature macro: FP_ARB_RSP_REG_EN adds a response register stage.

module fp_add_arbiter
    import fp_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FP_LAT  = FP_ADD_LAT_DEFAULT,
    parameter int TAG_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_val,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_gnt,
    output logic [31:0]              add_a,
    output logic [31:0]              add_b,
    output logic                     add_en,
    output logic                     add_sub,
    input  logic [31:0]              add_y,
    output logic [NUM_REQ-1:0]       rsp_val,
    output logic [31:0]              rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } arb_slot_t;

    arb_state_t      state_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] lock_id_reg;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;

    logic [NUM_REQ-1:0] grant_vec;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    logic [31:0]      a_masked   [NUM_REQ];
    logic [31:0]      b_masked   [NUM_REQ];
    logic [TAG_W-1:0] tag_masked [NUM_REQ];
    logic [TAG_W-1:0] sel_tag;
    logic             sel_last;

    fp_add_arbiter_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) rr_picker (
        .req   (req_val),
        .ptr   (rr_ptr_reg),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant: round-robin pick when arbitrating, only the lock owner when locked.
    always_comb begin
        grant_vec = '0;
        grant_idx = lock_id_reg;
        grant_any = 1'b0;
        if (rst_n) begin
            if (state_reg == ARB) begin
                grant_vec = pick_gnt;
                grant_idx = pick_idx;
                grant_any = pick_found;
            end else if (req_val[lock_id_reg]) begin
                grant_vec[lock_id_reg] = 1'b1;
                grant_any              = 1'b1;
            end
        end
    end

    assign req_gnt = grant_vec;

    // Per-requester operand slices masked by the one-hot grant.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign a_masked[gi]   = grant_vec[gi] ? req_a[gi*32 +: 32] : 32'h0;
            assign b_masked[gi]   = grant_vec[gi] ? req_b[gi*32 +: 32] : 32'h0;
            assign tag_masked[gi] = grant_vec[gi] ? req_tag[gi*TAG_W +: TAG_W] : '0;
        end
    endgenerate

    // OR-reduce the masked slices into the single adder port.
    always_comb begin
        add_a   = 32'h0;
        add_b   = 32'h0;
        sel_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            add_a   = add_a | a_masked[i];
            add_b   = add_b | b_masked[i];
            sel_tag = sel_tag | tag_masked[i];
        end
    end

    assign add_en   = grant_any;
    assign add_sub  = |(req_sub & grant_vec);
    assign sel_last = |(req_last & grant_vec);

    // Arbitration state: enter LOCK on a non-final grant, advance pointer past
    // the requester whose single op or burst just finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ARB;
            rr_ptr_reg  <= '0;
            lock_id_reg <= '0;
        end else if (grant_any) begin
            case (state_reg)
                ARB: begin
                    if (!sel_last) begin
                        state_reg   <= LOCK;
                        lock_id_reg <= grant_idx;
                    end else begin
                        rr_ptr_reg <= ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
                    end
                end
                LOCK: begin
                    if (sel_last) begin
                        state_reg  <= ARB;
                        rr_ptr_reg <= ID_W'(wrap_inc(int'(lock_id_reg), NUM_REQ));
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    arb_slot_t        slot_reg [FP_LAT];
    logic [FP_LAT-1:0] slot_valid_vec;

    // Slot 0 captures the op issued this cycle (or an empty slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg[0] <= '0;
        end else begin
            slot_reg[0].valid <= grant_any;
            slot_reg[0].id    <= grant_idx;
            slot_reg[0].tag   <= sel_tag;
        end
    end

    // Remaining slots shift unconditionally, tracking the adder pipeline.
    generate
        for (genvar gi = 1; gi < FP_LAT; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= '0;
                end else begin
                    slot_reg[gi] <= slot_reg[gi-1];
                end
            end
        end
        for (genvar gi = 0; gi < FP_LAT; gi++) begin : g_valid
            assign slot_valid_vec[gi] = slot_reg[gi].valid;
        end
    endgenerate

    arb_slot_t          out_slot;
    logic [NUM_REQ-1:0] rsp_val_comb;
    logic [31:0]        rsp_data_comb;

    assign out_slot = slot_reg[FP_LAT-1];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_val_comb[gi] = out_slot.valid && (out_slot.id == ID_W'(gi));
        end
    endgenerate

    // Adder output is not ours during reset; hold the data bus at zero then.
    assign rsp_data_comb = rst_n ? add_y : 32'h0;

`ifdef FP_ARB_RSP_REG_EN
    logic [NUM_REQ-1:0] rsp_val_reg;
    logic [31:0]        rsp_data_reg;
    logic [TAG_W-1:0]   rsp_tag_reg;

    // Output register stage for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_val_reg  <= '0;
            rsp_data_reg <= 32'h0;
            rsp_tag_reg  <= '0;
        end else begin
            rsp_val_reg  <= rsp_val_comb;
            rsp_data_reg <= rsp_data_comb;
            rsp_tag_reg  <= out_slot.tag;
        end
    end

    assign rsp_val  = rsp_val_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_tag  = rsp_tag_reg;
    assign busy     = (|slot_valid_vec) || (state_reg == LOCK) || (|rsp_val_reg);
`else
    assign rsp_val  = rsp_val_comb;
    assign rsp_data = rsp_data_comb;
    assign rsp_tag  = out_slot.tag;
    assign busy     = (|slot_valid_vec) || (state_reg == LOCK);
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter. Expected responses are pushed to a
// scoreboard queue at issue time and compared when due. The adder is a
// table-lookup pipeline model. Honors FP_ARB_RSP_REG_EN for response latency.

module tb_fp_add_arbiter;

    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int TW  = 3;
`ifdef FP_ARB_RSP_REG_EN
    localparam int RSP_LAT = LAT + 1;
`else
    localparam int RSP_LAT = LAT;
`endif

    // Operation table: a, b, sub, exact IEEE-754 result.
    localparam logic [31:0] OP_A [6] = '{32'h3F800000, 32'h40A00000, 32'h3F000000,
                                         32'h41200000, 32'h40000000, 32'h3F800000};
    localparam logic [31:0] OP_B [6] = '{32'h40000000, 32'h3FC00000, 32'h3E800000,
                                         32'h40200000, 32'h40000000, 32'h3F800000};
    localparam logic        OP_S [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] OP_Y [6] = '{32'h40400000, 32'h40600000, 32'h3F400000,
                                         32'h40F00000, 32'h40800000, 32'h00000000};

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_val;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_sub;
    logic [N-1:0]      req_last;
    logic [N*TW-1:0]   req_tag;
    logic [N-1:0]      req_gnt;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_en;
    logic              add_sub;
    logic [31:0]       add_y;
    logic [N-1:0]      rsp_val;
    logic [31:0]       rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic              busy;

    fp_add_arbiter #(
        .NUM_REQ (N),
        .FP_LAT  (LAT),
        .TAG_W   (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_val  (req_val),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_sub  (req_sub),
        .req_last (req_last),
        .req_tag  (req_tag),
        .req_gnt  (req_gnt),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_en   (add_en),
        .add_sub  (add_sub),
        .add_y    (add_y),
        .rsp_val  (rsp_val),
        .rsp_data (rsp_data),
        .rsp_tag  (rsp_tag),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Adder model: table lookup, LAT-cycle pipeline.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        for (int k = 0; k < 6; k++) begin
            if (OP_A[k] == a && OP_B[k] == b && OP_S[k] == s) return OP_Y[k];
        end
        return 32'hDEADBEEF;
    endfunction

    logic [31:0] y_pipe [LAT];
    initial for (int k = 0; k < LAT; k++) y_pipe[k] = 32'h0;
    always @(posedge clk) begin
        y_pipe[0] <= add_en ? model_add(add_a, add_b, add_sub) : 32'h0;
        for (int k = 1; k < LAT; k++) y_pipe[k] <= y_pipe[k-1];
    end
    assign add_y = y_pipe[LAT-1];

    // Requester stimulus state.
    logic          r_val  [N];
    int            r_op   [N];
    logic          r_last [N];
    logic [TW-1:0] r_tag  [N];

    typedef struct {
        logic [N-1:0]  val;
        logic [31:0]   data;
        logic [TW-1:0] tag;
        int            due;
    } exp_t;
    exp_t sb_q[$];

    task automatic set_req(input int i, input logic v, input int op, input logic last,
                           input logic [TW-1:0] tag);
        r_val[i]  = v;
        r_op[i]   = op;
        r_last[i] = last;
        r_tag[i]  = tag;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 1'b1, '0);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_val[i]            = r_val[i];
            req_a[i*32 +: 32]     = OP_A[r_op[i]];
            req_b[i*32 +: 32]     = OP_B[r_op[i]];
            req_sub[i]            = OP_S[r_op[i]];
            req_last[i]           = r_last[i];
            req_tag[i*TW +: TW]   = r_tag[i];
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return 0;
    endfunction

    // One cycle: apply stimulus, check grant/adder drive, schedule response.
    // exp_busy: 0/1 checked, anything else skipped.
    task automatic step(input logic [N-1:0] exp_gnt, input int exp_busy);
        exp_t e;
        int   i;
        @(posedge clk);
        #1;
        drive_reqs();
        @(negedge clk);
        check_eq("req_gnt", req_gnt, exp_gnt);
        check_eq("add_en", add_en, |exp_gnt);
        if (exp_busy == 0 || exp_busy == 1) check_eq("busy", busy, exp_busy[0]);
        if (exp_gnt != '0) begin
            i = oh_idx(exp_gnt);
            check_eq("add_a", add_a, OP_A[r_op[i]]);
            check_eq("add_b", add_b, OP_B[r_op[i]]);
            check_eq("add_sub", add_sub, OP_S[r_op[i]]);
            e.val  = exp_gnt;
            e.data = OP_Y[r_op[i]];
            e.tag  = r_tag[i];
            e.due  = cyc + RSP_LAT;
            sb_q.push_back(e);
            $display("issue cyc=%0d req=%0d tag=%0d exp_y=%h", cyc, i, r_tag[i], e.data);
        end else begin
            check_eq("add_idle", {add_a | add_b} | {31'h0, add_sub}, 32'h0);
        end
    endtask

    task automatic drain();
        repeat (RSP_LAT + 1) step('0, 2);
        step('0, 0);
    endtask

    // One-cycle reset pulse; anything in flight is expected to vanish.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        clear_reqs();
        drive_reqs();
        @(negedge clk);
        check_eq("rst_gnt", req_gnt, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_add_en", add_en, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Response monitor: compare against the scoreboard head when due.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            check_eq("rsp_val", rsp_val, sb_q[0].val);
            check_eq("rsp_data", rsp_data, sb_q[0].data);
            check_eq("rsp_tag", rsp_tag, sb_q[0].tag);
            $display("resp  cyc=%0d val=%b data=%h tag=%0d", cyc, rsp_val, rsp_data, rsp_tag);
            void'(sb_q.pop_front());
        end else begin
            check_eq("rsp_idle", rsp_val, '0);
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i, 1'b1, TW'(i));
        drive_reqs();

        // Reset state with every requester asking.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_gnt", req_gnt, '0);
        check_eq("reset_add_en", add_en, 1'b0);
        check_eq("reset_rsp_val", rsp_val, '0);
        check_eq("reset_rsp_data", rsp_data, 32'h0);
        check_eq("reset_rsp_tag", rsp_tag, '0);
        check_eq("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_reqs();
        drive_reqs();

        // Single op: 1.0 + 2.0, tag 5.
        set_req(0, 1'b1, 0, 1'b1, 3'd5);
        step(4'b0001, 0);
        clear_reqs();
        step('0, 1);
        drain();

        // Round-robin from a fresh pointer.
        pulse_reset();
        set_req(0, 1'b1, 0, 1'b1, 3'd1);
        set_req(1, 1'b1, 1, 1'b1, 3'd2);
        set_req(2, 1'b1, 2, 1'b1, 3'd3);
        set_req(3, 1'b1, 3, 1'b1, 3'd4);
        step(4'b0001, 2);
        step(4'b0010, 1);
        step(4'b0100, 1);
        step(4'b1000, 1);
        step(4'b0001, 1);
        clear_reqs();
        drain();

        // Burst lock: pointer is at 1; req 1 bursts 3 ops while req 2 waits.
        set_req(1, 1'b1, 4, 1'b0, 3'd6);
        set_req(2, 1'b1, 5, 1'b1, 3'd7);
        step(4'b0010, 2);
        set_req(1, 1'b1, 1, 1'b0, 3'd0);
        step(4'b0010, 1);
        set_req(1, 1'b1, 3, 1'b1, 3'd2);
        step(4'b0010, 1);
        set_req(1, 1'b0, 0, 1'b1, 3'd0);
        step(4'b0100, 1);
        clear_reqs();
        drain();

        // Lock gap: req 1 locks, drops valid for 2 cycles, req 3 must wait.
        set_req(1, 1'b1, 2, 1'b0, 3'd3);
        step(4'b0010, 2);
        set_req(1, 1'b0, 2, 1'b0, 3'd3);
        set_req(3, 1'b1, 4, 1'b1, 3'd1);
        step('0, 1);
        step('0, 1);
        set_req(1, 1'b1, 0, 1'b1, 3'd4);
        step(4'b0010, 1);
        set_req(1, 1'b0, 0, 1'b1, 3'd0);
        step(4'b1000, 1);
        clear_reqs();
        drain();

        // Reset mid-flight: 3 ops issued, pointer left at 3, then reset.
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i, 1'b1, TW'(i + 1));
        step(4'b0001, 2);
        step(4'b0010, 1);
        step(4'b0100, 1);
        pulse_reset();
        repeat (RSP_LAT + 2) step('0, 0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5 - i, 1'b1, TW'(i));
        step(4'b0001, 0);
        clear_reqs();
        drain();

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
